// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field positions, FSM states.
// Optional MUL/DIV support is enabled by defining CU_MUL_DIV_EN.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

`ifdef CU_MUL_DIV_EN
    localparam logic MUL_DIV_EN = 1'b1;
`else
    localparam logic MUL_DIV_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T1W   = 4'd3,
        ST_T2    = 4'd4,
        ST_T3    = 4'd5,
        ST_T4    = 4'd6,
        ST_T5    = 4'd7,
        ST_T6    = 4'd8,
        ST_HALT  = 4'd9
    } cu_state_t;

    function automatic logic is_mul_div(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // MUL/DIV only count as ALU ops when the wide-result path is built in.
    function automatic logic is_alu_op(input logic [4:0] op);
        logic base;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: base = 1'b1;
            default:                       base = 1'b0;
        endcase
        return base || (MUL_DIV_EN && is_mul_div(op));
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// 4-bit register field to one-hot strobe decoder with enable; selects past NREGS-1 decode to zero.
module reg_field_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       sel,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    localparam logic [NREGS-1:0] ONE = NREGS'(1);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = ONE << sel;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the single-bus Datapath strobes.
// Define CU_MUL_DIV_EN to add MUL/DIV with the extra HI/LO write-back cycle (T6).
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic [31:0]      IR,
    input  logic             mem_ready,
    input  logic             Stop,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowout,
    output logic             Zhiout,
    output logic             HIin,
    output logic             LOin,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic [4:0]       IRout,
    output logic             Run,
    output logic             illegal
);

    cu_state_t state;
    cu_state_t state_nxt;
    logic      illegal_nxt;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       unused_ir;
    logic       mul_div_path;
    logic       stop_target;

    logic       rout_en;
    logic [3:0] rout_sel;
    logic       rin_en;

    assign opcode    = IR[IR_OP_MSB:IR_OP_LSB];
    assign ra        = IR[IR_RA_MSB:IR_RA_LSB];
    assign rb        = IR[IR_RB_MSB:IR_RB_LSB];
    assign rc        = IR[IR_RC_MSB:IR_RC_LSB];
    assign unused_ir = ^IR[IR_RC_LSB-1:0];

    assign mul_div_path = MUL_DIV_EN && is_mul_div(opcode);
    assign stop_target  = Stop;

    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            state   <= ST_RESET;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            illegal <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        illegal_nxt = 1'b0;
        case (state)
            ST_RESET: state_nxt = ST_T0;
            ST_T0:    state_nxt = ST_T1;
            ST_T1:    state_nxt = ST_T1W;
            ST_T1W:   if (mem_ready) state_nxt = ST_T2;
            ST_T2: begin
                // A HALT opcode wins over Stop; NOP and illegal opcodes are instruction boundaries.
                if (is_alu_op(opcode)) begin
                    state_nxt = ST_T3;
                end else if (opcode == OP_HALT) begin
                    state_nxt = ST_HALT;
                end else begin
                    illegal_nxt = (opcode != OP_NOP);
                    state_nxt   = stop_target ? ST_HALT : ST_T0;
                end
            end
            ST_T3:    state_nxt = ST_T4;
            ST_T4:    state_nxt = ST_T5;
            ST_T5: begin
                if (mul_div_path) state_nxt = ST_T6;
                else              state_nxt = stop_target ? ST_HALT : ST_T0;
            end
            ST_T6:    state_nxt = stop_target ? ST_HALT : ST_T0;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowout  = 1'b0;
        Zhiout   = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IRout    = 5'b0;
        rout_en  = 1'b0;
        rout_sel = rb;
        rin_en   = 1'b0;
        Run      = (state != ST_RESET) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
            end
            ST_T1W: begin
                Read  = 1'b1;
                MDRin = mem_ready;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                rout_en = 1'b1;
                Yin     = 1'b1;
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_sel = rc;
                IRout    = opcode;
                Zin      = 1'b1;
            end
            ST_T5: begin
                Zlowout = 1'b1;
`ifdef CU_MUL_DIV_EN
                LOin   = mul_div_path;
                rin_en = !mul_div_path;
`else
                rin_en = 1'b1;
`endif
            end
`ifdef CU_MUL_DIV_EN
            ST_T6: begin
                Zhiout = 1'b1;
                HIin   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    reg_field_decoder #(.NREGS(NREGS)) u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (Rout)
    );

    reg_field_decoder #(.NREGS(NREGS)) u_rin_dec (
        .sel    (ra),
        .en     (rin_en),
        .onehot (Rin)
    );

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: per-cycle vector table through a scoreboard, plus reset and latency sequences.
module tb_cpu_control_unit;

    localparam int NREGS = 16;
    localparam int W     = 53;

    typedef enum int {E_RST, E_T0, E_T1, E_T1W, E_T2, E_T3, E_T4, E_T5, E_T6, E_HALT} exp_st_e;

    typedef struct packed {
        logic pcout, marin, incpc, zin, pcin, read, mdrin, mdrout, irin, yin;
        logic zlowout, zhiout, hiin, loin, run, ill;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  irout;
    } out_t;

    typedef struct {
        logic        clr;
        logic        rdy;
        logic        stp;
        logic [31:0] ir;
        exp_st_e     st;
        logic        ill;
    } vec_t;

    logic             clk;
    logic             Clear;
    logic [31:0]      IR;
    logic             mem_ready;
    logic             Stop;
    logic             PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic             Zlowout, Zhiout, HIin, LOin, Run, illegal;
    logic [NREGS-1:0] Rout;
    logic [NREGS-1:0] Rin;
    logic [4:0]       IRout;

    logic [W-1:0] act;
    logic [W-1:0] exp_q[$];
    vec_t         vecs[$];
    int           tests;
    int           fails;

    cpu_control_unit #(.NREGS(NREGS)) dut (
        .clk       (clk),
        .Clear     (Clear),
        .IR        (IR),
        .mem_ready (mem_ready),
        .Stop      (Stop),
        .PCout     (PCout),
        .MARin     (MARin),
        .IncPC     (IncPC),
        .Zin       (Zin),
        .PCin      (PCin),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .Zlowout   (Zlowout),
        .Zhiout    (Zhiout),
        .HIin      (HIin),
        .LOin      (LOin),
        .Rout      (Rout),
        .Rin       (Rin),
        .IRout     (IRout),
        .Run       (Run),
        .illegal   (illegal)
    );

    assign act = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
                  Zlowout, Zhiout, HIin, LOin, Run, illegal, Rout, Rin, IRout};

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                           input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    function automatic logic is_md(input logic [4:0] op);
`ifdef CU_MUL_DIV_EN
        return (op == 5'b01111) || (op == 5'b10000);
`else
        return 1'b0;
`endif
    endfunction

    // Expected strobes for each sequencer cycle, straight from the cycle table.
    function automatic out_t exp_of(input exp_st_e st, input logic [31:0] ir,
                                    input logic rdy, input logic ill);
        out_t        o;
        logic [15:0] one;
        one   = 16'h0001;
        o     = '0;
        o.ill = ill;
        o.run = (st != E_RST) && (st != E_HALT);
        case (st)
            E_T0:  begin o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.zin = 1'b1; end
            E_T1:  begin o.zlowout = 1'b1; o.pcin = 1'b1; o.read = 1'b1; end
            E_T1W: begin o.read = 1'b1; o.mdrin = rdy; end
            E_T2:  begin o.mdrout = 1'b1; o.irin = 1'b1; end
            E_T3:  begin o.rout = one << ir[22:19]; o.yin = 1'b1; end
            E_T4:  begin o.rout = one << ir[18:15]; o.irout = ir[31:27]; o.zin = 1'b1; end
            E_T5: begin
                o.zlowout = 1'b1;
                if (is_md(ir[31:27])) o.loin = 1'b1;
                else                  o.rin  = one << ir[26:23];
            end
            E_T6:  begin o.zhiout = 1'b1; o.hiin = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add_v(input logic clr, input logic rdy, input logic stp,
                         input logic [31:0] ir, input exp_st_e st, input logic ill);
        vec_t v;
        v.clr = clr; v.rdy = rdy; v.stp = stp; v.ir = ir; v.st = st; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Zero-wait fetch: T0, T1, T1W, T2.
    task automatic add_fetch(input logic [31:0] ir, input logic stp2, input logic ill0);
        add_v(1'b1, 1'b1, 1'b0, ir, E_T0, ill0);
        add_v(1'b1, 1'b1, 1'b0, ir, E_T1, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, ir, E_T1W, 1'b0);
        add_v(1'b1, 1'b1, stp2, ir, E_T2, 1'b0);
    endtask

    task automatic add_exec(input logic [31:0] ir, input logic stp5);
        add_v(1'b1, 1'b1, 1'b0, ir, E_T3, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, ir, E_T4, 1'b0);
        add_v(1'b1, 1'b1, stp5, ir, E_T5, 1'b0);
    endtask

    task automatic add_reset();
        add_v(1'b0, 1'b1, 1'b0, 32'h0, E_RST, 1'b0);
        add_v(1'b0, 1'b1, 1'b0, 32'h0, E_RST, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, 32'h0, E_RST, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Clear = 1'b1;
    endtask

    task automatic run_lat(input string name, input logic [31:0] ir, input int waits, input int exp_lat);
        int start, w, t1w_reads, mdr_cnt, lat;
        bit done;
        start = -1; w = 0; t1w_reads = 0; mdr_cnt = 0; lat = 0; done = 1'b0;
        IR = ir; Stop = 1'b0; mem_ready = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (PCout && start < 0) start = cyc;
            if (Read && !PCin) begin
                t1w_reads++;
                if (w < waits) begin
                    w++;
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            #1;
            if (MDRin) mdr_cnt++;
            if (Rin != '0) begin
                lat  = cyc - start + 1;
                done = 1'b1;
            end
        end
        check({name, "_done"}, 64'(done), 64'(1));
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_wait_reads"}, 64'(t1w_reads), 64'(waits + 1));
        check({name, "_mdrin_cycles"}, 64'(mdr_cnt), 64'(1));
    endtask

    initial begin
        logic [31:0] ir_or, ir_add, ir_ill, ir_nop, ir_halt, ir_mul, ir_shl;
        logic [W-1:0] got, exp;
        bit found;

        tests = 0;
        fails = 0;
        Clear = 1'b1; IR = 32'h0; mem_ready = 1'b0; Stop = 1'b0;
        #2 Clear = 1'b0;

        ir_or   = 32'h50A18000;
        ir_add  = mk_ir(5'b00011, 4'd4, 4'd5, 4'd6);
        ir_ill  = mk_ir(5'b11111, 4'd7, 4'd1, 4'd2);
        ir_nop  = mk_ir(5'b11010, 4'd3, 4'd3, 4'd3);
        ir_halt = mk_ir(5'b11011, 4'd1, 4'd1, 4'd1);
        ir_mul  = mk_ir(5'b01111, 4'd9, 4'd10, 4'd11);
        ir_shl  = mk_ir(5'b00110, 4'd15, 4'd0, 4'd14);

        // Reset release, then OR R1,R2,R3 with no memory wait.
        add_reset();
        add_fetch(ir_or, 1'b0, 1'b0);
        add_exec(ir_or, 1'b0);
        // ADD with three wait cycles; Stop high mid-instruction must be ignored.
        add_v(1'b1, 1'b1, 1'b0, ir_add, E_T0, 1'b0);
        add_v(1'b1, 1'b0, 1'b0, ir_add, E_T1, 1'b0);
        add_v(1'b1, 1'b0, 1'b0, ir_add, E_T1W, 1'b0);
        add_v(1'b1, 1'b0, 1'b0, ir_add, E_T1W, 1'b0);
        add_v(1'b1, 1'b0, 1'b0, ir_add, E_T1W, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, ir_add, E_T1W, 1'b0);
        add_v(1'b1, 1'b1, 1'b1, ir_add, E_T2, 1'b0);
        add_v(1'b1, 1'b1, 1'b1, ir_add, E_T3, 1'b0);
        add_v(1'b1, 1'b1, 1'b1, ir_add, E_T4, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, ir_add, E_T5, 1'b0);
        // Illegal opcode, then a NOP.
        add_fetch(ir_ill, 1'b0, 1'b0);
        add_fetch(ir_nop, 1'b0, 1'b1);
        // MUL: execute path with the wide-result option, illegal path without it.
        add_fetch(ir_mul, 1'b0, 1'b0);
`ifdef CU_MUL_DIV_EN
        add_exec(ir_mul, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, ir_mul, E_T6, 1'b0);
        add_fetch(ir_shl, 1'b0, 1'b0);
`else
        add_fetch(ir_shl, 1'b0, 1'b1);
`endif
        // SHL R15,R0,R14: register field boundaries.
        add_exec(ir_shl, 1'b0);
        // NOP with Stop at T2 halts; HALT holds until Clear.
        add_fetch(ir_nop, 1'b1, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, ir_nop, E_HALT, 1'b0);
        add_v(1'b1, 1'b0, 1'b1, ir_nop, E_HALT, 1'b0);
        add_reset();
        // HALT opcode together with Stop.
        add_fetch(ir_halt, 1'b1, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, ir_halt, E_HALT, 1'b0);
        add_v(1'b1, 1'b1, 1'b0, ir_add, E_HALT, 1'b0);
        add_reset();
        // Stop sampled at T5 of an ADD.
        add_fetch(ir_add, 1'b0, 1'b0);
        add_exec(ir_add, 1'b1);
        add_v(1'b1, 1'b1, 1'b0, ir_add, E_HALT, 1'b0);
        add_v(1'b1, 1'b1, 1'b1, ir_add, E_HALT, 1'b0);
        add_v(1'b1, 1'b0, 1'b0, ir_add, E_HALT, 1'b0);

        // Driver: inputs just after the rising edge, outputs compared on the falling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            Clear     = vecs[i].clr;
            mem_ready = vecs[i].rdy;
            Stop      = vecs[i].stp;
            IR        = vecs[i].ir;
            exp_q.push_back(exp_of(vecs[i].st, vecs[i].ir, vecs[i].rdy, vecs[i].ill));
            @(negedge clk);
            got = act;
            exp = exp_q.pop_front();
            check($sformatf("vec[%0d]", i), 64'(got), 64'(exp));
        end

        // Clear during T1W drops Read without waiting for a clock edge.
        Stop = 1'b0;
        mem_ready = 1'b0;
        IR = ir_add;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (Read && !PCin) found = 1'b1;
        end
        check("reach_t1w", 64'(found), 64'(1));
        check("t1w_read_high", 64'(Read), 64'(1));
        Clear = 1'b0;
        #1;
        exp_q.push_back(exp_of(E_RST, IR, mem_ready, 1'b0));
        check("async_clear_drop", 64'(act), 64'(exp_q.pop_front()));
        @(negedge clk);
        Clear = 1'b1;
        @(negedge clk);
        exp_q.push_back(exp_of(E_T0, IR, mem_ready, 1'b0));
        check("restart_t0", 64'(act), 64'(exp_q.pop_front()));

        run_lat("lat_zero_wait", ir_add, 0, 7);
        run_lat("lat_three_wait", ir_or, 3, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Hardwired control sequencer for the single-bus CPU `Datapath`. It fetches each instruction over a ready/Read memory handshake. It decodes the 5-bit opcode and drives the register, bus and ALU strobes through the T0..T5 cycle sequence for register-format ALU instructions. It replaces hand-driven testbench strobes and sits between the instruction register and the `Datapath` control inputs.

## Interface
Parameters:
- `NREGS`, 16, number of general registers; sets the width of the one-hot register strobes.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `Clear`  in  1  reset, asynchronous, active-low.
- `IR`  in  32  instruction register contents; opcode `IR[31:27]`, Ra `IR[26:23]`, Rb `IR[22:19]`, Rc `IR[18:15]`.
- `mem_ready`  in  1  memory has data valid on `Mdatain`.
- `Stop`  in  1  halt request, honoured at an instruction boundary.
- `PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhiout, HIin, LOin`  out  1 each  datapath strobes.
- `Rout`  out  NREGS  one-hot register-to-bus enable.
- `Rin`  out  NREGS  one-hot register load enable.
- `IRout`  out  5  ALU operation select.
- `Run`  out  1  high while executing; low in reset and HALT.
- `illegal`  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- States: RESET, T0, T1, T1W, T2, T3, T4, T5, T6 (only with the macro), HALT.
- RESET: entered while `Clear`=0. The next state after `Clear` is released is T0.
- T0: `PCout`, `MARin`, `IncPC`, `Zin`.
- T1: `Zlowout`, `PCin`, `Read`. Always followed by T1W.
- T1W: hold `Read`. If `mem_ready`=1, assert `MDRin` in that same cycle (Mealy) and go to T2. Otherwise stay in T1W.
- T2: `MDRout`, `IRin`. Then decode `IR[31:27]`, which is valid on the next cycle:
  - ALU ops go to T3.
  - NOP (11010) goes to T0.
  - HALT (11011) goes to HALT.
  - Any other opcode goes to T0 and pulses `illegal`.
- Opcodes: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010; MUL 01111 and DIV 10000 only with the macro.
- T3: `Rout[Rb]`, `Yin`.
- T4: `Rout[Rc]`, `IRout`=opcode, `Zin`.
- T5: `Zlowout`, `Rin[Ra]`. Next state is HALT if `Stop`=1, otherwise T0.
- HALT: all strobes 0, `Run`=0. Only reset exits HALT.
- At most one bit of `Rout` is set, and at most one bit of `Rin`. `IRout` is 0 outside T4.
- Register fields are 4 bits. `Rb`, `Rc` and `Ra` index the one-hot outputs directly; with NREGS=16 there is no out-of-range case.

## Timing
- Reset values: every output 0, including `Run`, `illegal`, `Rout` and `Rin`.
- Outputs are decoded from the registered state, with no added pipeline stage. `MDRin` is the only Mealy output.
- ALU instruction latency with `mem_ready` already high in T1W: 7 cycles from T0 to the end of T5. Each wait cycle adds 1.
- `Stop` is sampled only in T5 and in T2 when the opcode is NOP or illegal. It is ignored mid-instruction.
- When `Stop` and a HALT opcode arrive in the same cycle, the result is HALT.
- `Clear` asserted in any state, including mid-wait in T1W: the block goes to RESET immediately and all strobes drop the same instant.

## Configuration
- `CU_MUL_DIV_EN` defined:
  - MUL and DIV are decoded as ALU ops.
  - T4 drives `IRout`=opcode, same as other ALU ops.
  - T5 asserts `Zlowout` + `LOin` instead of `Rin`.
  - T6 asserts `Zhiout` + `HIin`, then goes to T0 or HALT under the same rule as T5.
  - Latency is 8 cycles.
- `CU_MUL_DIV_EN` undefined: MUL and DIV opcodes take the illegal path, T6 does not exist, and `Zhiout`, `HIin` and `LOin` are tied to 0.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams;
  - IR field bit positions;
  - state enum.
- One sub-module, `reg_field_decoder`: a 4-to-NREGS one-hot decoder with an enable, instantiated once for `Rout` and once for `Rin`.
- The FSM and strobe decode live in `cpu_control_unit`.

## Test plan
- Reset release: hold `Clear`=0 for 2 cycles, then release with `mem_ready`=1. Expect all outputs 0 during reset, T0 strobes (`PCout`, `MARin`, `IncPC`, `Zin`) in the first cycle after release, and `Run`=1.
- OR R1,R2,R3 (IR=0x50A18000), zero wait: expect `Rout`=0x0004 with `Yin` in T3; `Rout`=0x0008 with `IRout`=01010 and `Zin` in T4; `Rin`=0x0002 with `Zlowout` in T5; 7 cycles total.
- Memory wait: hold `mem_ready`=0 for 3 cycles in T1W. Expect `Read` high for 4 cycles, `MDRin` only in the cycle `mem_ready` rises, and latency 10.
- Illegal opcode 11111: expect a one-cycle `illegal` pulse, a return to T0, and no `Rin` bit set.
- HALT opcode, then `Stop`=1 during ADD at T5: expect `Run`=0 with all strobes 0 and the block held there until `Clear`.
- Mid-fetch reset: pull `Clear` low in T1W. Expect `Read` to drop the same cycle, and after release the sequence restarts at T0.
